multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 19 +
 rtl/multicycle_control.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Memory request/ready handshake between the multicycle control FSM
// and the instruction/data memory.
interface multicycle_control_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      output mem_ready
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: fetch, decode, execute, memory and
// writeback sequencing with a memory wait timeout that traps.
module multicycle_control #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          opcode,
   input  logic [2:0]          funct3,
   input  logic                funct7_5,
   input  logic                br_taken,
   multicycle_control_if.master mem,
   output logic                ir_we,
   output logic                pc_we,
   output logic [1:0]          pc_sel,
   output logic                reg_write,
   output logic [1:0]          wb_sel,
   output logic                alu_src_b,
   output logic [3:0]          alu_op,
   output logic [2:0]          state,
   output logic                trap,
   output logic [31:0]         retire_count
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      TRAP      = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      K_R, K_I, K_LD, K_ST, K_BR,
      K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD
   } kind_t;

   state_t          state_q, state_n;
   kind_t           kind_d, kind_q;
   logic [3:0]      op_d, op_q;
   logic            srcb_d, srcb_q;
   logic [CW-1:0]   wait_q;
   logic [31:0]     retire_q;
   logic            req, we, tmo;

   assign mem.mem_req  = req;
   assign mem.mem_we   = we;
   assign state        = state_q;
   assign retire_count = retire_q;

   // Classify the instruction from the opcode held in the IR.
   always_comb begin
      kind_d = K_BAD;
      case (opcode)
         7'b0110011: kind_d = K_R;
         7'b0010011: kind_d = K_I;
         7'b0000011: kind_d = K_LD;
         7'b0100011: kind_d = K_ST;
         7'b1100011: kind_d = K_BR;
         7'b1101111: kind_d = K_JAL;
         7'b1100111: kind_d = K_JALR;
         7'b0110111: kind_d = K_LUI;
         7'b0010111: kind_d = K_AUIPC;
         default:    kind_d = K_BAD;
      endcase
   end

   // ALU operation and operand-B select for the decoded type.
   always_comb begin
      op_d   = 4'b0000;
      srcb_d = 1'b1;
      case (kind_d)
         K_R: begin
            op_d   = {funct7_5, funct3};
            srcb_d = 1'b0;
         end
         K_I:     op_d = {(funct3 == 3'b101) & funct7_5, funct3};
         K_BR: begin
            op_d   = 4'b1000;
            srcb_d = 1'b0;
         end
         K_LUI:   op_d = 4'b1111;
         default: op_d = 4'b0000;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= FETCH;
      else      state_q <= state_n;
   end

   // Latch type and ALU controls while in DECODE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kind_q <= K_R;
         op_q   <= 4'b0000;
         srcb_q <= 1'b0;
      end else if (state_q == DECODE) begin
         kind_q <= kind_d;
         op_q   <= op_d;
         srcb_q <= srcb_d;
      end
   end

   // Memory wait counter: cleared on entry to an access state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q <= '0;
      end else if (state_n != state_q &&
                   (state_n == FETCH || state_n == MEMORY)) begin
         wait_q <= '0;
      end else if ((state_q == FETCH || state_q == MEMORY) &&
                   !mem.mem_ready) begin
         wait_q <= wait_q + CW'(1);
      end
   end

   // Retired instruction counter, one per PC update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) retire_q <= '0;
      else      retire_q <= retire_q + {31'b0, pc_we};
   end

   // Next state and control outputs; everything low during reset.
   always_comb begin
      state_n   = state_q;
      req       = 1'b0;
      we        = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      alu_src_b = 1'b0;
      alu_op    = 4'b0000;
      trap      = 1'b0;
      tmo       = !mem.mem_ready &&
                  (wait_q == CW'(TIMEOUT_CYCLES - 1));
      if (rst) begin
         case (state_q)
            FETCH: begin
               req = 1'b1;
               if (mem.mem_ready) begin
                  ir_we   = 1'b1;
                  state_n = DECODE;
               end else if (tmo) begin
                  state_n = TRAP;
               end
            end
            DECODE: begin
               state_n = (kind_d == K_BAD) ? TRAP : EXECUTE;
            end
            EXECUTE: begin
               alu_op    = op_q;
               alu_src_b = srcb_q;
               case (kind_q)
                  K_LD, K_ST: state_n = MEMORY;
                  K_BR: begin
                     pc_we   = 1'b1;
                     pc_sel  = {1'b0, br_taken};
                     state_n = FETCH;
                  end
                  default: state_n = WRITEBACK;
               endcase
            end
            MEMORY: begin
               alu_op    = op_q;
               alu_src_b = srcb_q;
               req       = 1'b1;
               we        = (kind_q == K_ST);
               if (mem.mem_ready) begin
                  if (kind_q == K_ST) begin
                     pc_we   = 1'b1;
                     state_n = FETCH;
                  end else begin
                     state_n = WRITEBACK;
                  end
               end else if (tmo) begin
                  state_n = TRAP;
               end
            end
            WRITEBACK: begin
               alu_op    = op_q;
               alu_src_b = srcb_q;
               reg_write = 1'b1;
               pc_we     = 1'b1;
               state_n   = FETCH;
               case (kind_q)
                  K_LD:         wb_sel = 2'd1;
                  K_JAL, K_JALR: wb_sel = 2'd2;
                  default:      wb_sel = 2'd0;
               endcase
               case (kind_q)
                  K_JAL:   pc_sel = 2'd1;
                  K_JALR:  pc_sel = 2'd2;
                  default: pc_sel = 2'd0;
               endcase
            end
            TRAP: begin
               trap    = 1'b1;
               state_n = TRAP;
            end
            default: state_n = TRAP;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a
// per-instruction behavioural model (latency, counts, selects).
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic        funct7_5 = 1'b0;
   logic        br_taken = 1'b0;
   logic        ir_we, pc_we, reg_write, alu_src_b, trap;
   logic [1:0]  pc_sel, wb_sel;
   logic [3:0]  alu_op;
   logic [2:0]  state;
   logic [31:0] retire_count;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_ret = 32'd0;

   multicycle_control_if mif ();

   multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7_5     (funct7_5),
      .br_taken     (br_taken),
      .mem          (mif),
      .ir_we        (ir_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .state        (state),
      .trap         (trap),
      .retire_count (retire_count)
   );

   always #5 clk = ~clk;

   // kinds: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC
   function automatic logic [6:0] opc(int k);
      case (k)
         0: return 7'b0110011;
         1: return 7'b0010011;
         2: return 7'b0000011;
         3: return 7'b0100011;
         4: return 7'b1100011;
         5: return 7'b1101111;
         6: return 7'b1100111;
         7: return 7'b0110111;
         default: return 7'b0010111;
      endcase
   endfunction

   function automatic logic [3:0] ref_alu(int k, logic [2:0] f3, logic f75);
      if (k == 0) return {f75, f3};
      if (k == 1) return {(f3 == 3'b101) ? f75 : 1'b0, f3};
      if (k == 4) return 4'b1000;
      if (k == 7) return 4'b1111;
      return 4'b0000;
   endfunction

   // One instruction: fetch ready after fd idle cycles, memory after md.
   task automatic run_instr(int k, logic [2:0] f3, logic f75, logic tk,
                            int fd, int md);
      bit ldst = (k == 2 || k == 3);
      bit has_wb = !(k == 3 || k == 4);
      int total = fd + 3 + (ldst ? md + 1 : 0) + (has_wb ? 1 : 0);
      int mem_at = fd + 3 + md;
      int n_req = 0, n_we = 0, n_ir = 0, n_rw = 0, n_pc = 0, n_trap = 0;
      int ir_at = -1, pc_at = -1;
      logic [1:0] psel = 2'd3, wsel = 2'd3;
      logic [3:0] aop = 4'hx;
      logic sb = 1'bx;
      logic [1:0] e_psel, e_wsel;
      e_psel = (k == 4) ? {1'b0, tk} : (k == 5) ? 2'd1 : (k == 6) ? 2'd2 : 2'd0;
      e_wsel = (k == 2) ? 2'd1 : (k == 5 || k == 6) ? 2'd2 : 2'd0;
      opcode = opc(k);
      funct3 = f3;
      funct7_5 = f75;
      br_taken = tk;
      for (int c = 0; c < total; c++) begin
         if (c <= fd) mif.mem_ready = (c == fd);
         else if (ldst && c >= fd + 3 && c <= mem_at) mif.mem_ready = (c == mem_at);
         else mif.mem_ready = 1'($urandom_range(0, 1));
         #2;
         if (mif.mem_req) n_req++;
         if (mif.mem_req && mif.mem_we) n_we++;
         if (ir_we) begin n_ir++; ir_at = c; end
         if (reg_write) begin n_rw++; wsel = wb_sel; end
         if (pc_we) begin n_pc++; pc_at = c; psel = pc_sel; aop = alu_op; sb = alu_src_b; end
         if (trap) n_trap++;
         @(negedge clk);
      end
      exp_ret = exp_ret + 32'd1;
      n_vec++; if (ir_at !== fd || n_ir !== 1) begin n_err++;
         $display("FAIL ir_we k=%0d: at %0d x%0d, want at %0d x1", k, ir_at, n_ir, fd); end
      n_vec++; if (n_req !== fd + 1 + (ldst ? md + 1 : 0)) begin n_err++;
         $display("FAIL mem_req_cycles k=%0d: got %0d want %0d", k, n_req, fd + 1 + (ldst ? md + 1 : 0)); end
      n_vec++; if (n_we !== ((k == 3) ? md + 1 : 0)) begin n_err++;
         $display("FAIL mem_we_cycles k=%0d: got %0d want %0d", k, n_we, (k == 3) ? md + 1 : 0); end
      n_vec++; if (n_rw !== (has_wb ? 1 : 0)) begin n_err++;
         $display("FAIL reg_write_cycles k=%0d: got %0d want %0d", k, n_rw, has_wb ? 1 : 0); end
      n_vec++; if (n_pc !== 1 || pc_at !== total - 1) begin n_err++;
         $display("FAIL latency k=%0d: pc_we x%0d at %0d, want x1 at %0d", k, n_pc, pc_at, total - 1); end
      n_vec++; if (psel !== e_psel) begin n_err++;
         $display("FAIL pc_sel k=%0d: got %0d want %0d", k, psel, e_psel); end
      n_vec++; if (aop !== ref_alu(k, f3, f75)) begin n_err++;
         $display("FAIL alu_op k=%0d: got %b want %b", k, aop, ref_alu(k, f3, f75)); end
      n_vec++; if (sb !== !(k == 0 || k == 4)) begin n_err++;
         $display("FAIL alu_src_b k=%0d: got %b want %b", k, sb, !(k == 0 || k == 4)); end
      if (has_wb) begin
         n_vec++; if (wsel !== e_wsel) begin n_err++;
            $display("FAIL wb_sel k=%0d: got %0d want %0d", k, wsel, e_wsel); end
      end
      n_vec++; if (n_trap !== 0) begin n_err++;
         $display("FAIL spurious_trap k=%0d: %0d cycles", k, n_trap); end
      n_vec++; if (retire_count !== exp_ret) begin n_err++;
         $display("FAIL retire k=%0d: got %h want %h", k, retire_count, exp_ret); end
   endtask

   // Reset pulse ending at a negedge with a fresh FETCH cycle starting.
   task automatic pulse_reset();
      rst = 1'b0;
      mif.mem_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_ret = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mif.mem_ready = 1'b1;
      opcode = 7'b0110011;
      br_taken = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2;
      n_vec++;
      if ({mif.mem_req, mif.mem_we, ir_we, pc_we, pc_sel, reg_write, wb_sel,
           alu_src_b, alu_op, state, trap} !== '0 || retire_count !== 32'd0) begin
         n_err++;
         $display("FAIL reset_outputs: req=%b ir=%b pc=%b st=%0d trap=%b ret=%h, want all 0",
                  mif.mem_req, ir_we, pc_we, state, trap, retire_count);
      end
      @(negedge clk);
      rst = 1'b1;
      mif.mem_ready = 1'b0;
      exp_ret = 32'd0;
      @(negedge clk);
      #2;
      n_vec++;
      if (state !== 3'd0 || mif.mem_req !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release: state=%0d req=%b, want 0/1", state, mif.mem_req);
      end
      @(negedge clk);
   endtask

   task automatic test_rtype_add();
      run_instr(0, 3'b000, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic test_load_delay();
      run_instr(2, 3'b010, 1'b0, 1'b0, 0, 3);
   endtask

   task automatic test_branch();
      run_instr(4, 3'b000, 1'b0, 1'b1, 0, 0);
      run_instr(4, 3'b001, 1'b0, 1'b0, 1, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++)
         run_instr(int'($urandom_range(0, 8)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
   endtask

   task automatic test_illegal();
      run_instr(1, 3'b101, 1'b1, 1'b0, 0, 0);
      opcode = 7'b1110011;
      mif.mem_ready = 1'b1;
      @(negedge clk);
      mif.mem_ready = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         mif.mem_ready = 1'($urandom_range(0, 1));
         #2;
         n_vec++;
         if (trap !== 1'b1 || mif.mem_req !== 1'b0 || pc_we !== 1'b0 ||
             retire_count !== exp_ret) begin
            n_err++;
            $display("FAIL illegal_trap c=%0d: trap=%b req=%b pc=%b ret=%h, want 1/0/0/%h",
                     c, trap, mif.mem_req, pc_we, retire_count, exp_ret);
         end
         @(negedge clk);
      end
      pulse_reset();
      #2;
      n_vec++;
      if (state !== 3'd0 || trap !== 1'b0 || mif.mem_req !== 1'b1) begin
         n_err++;
         $display("FAIL trap_exit: state=%0d trap=%b req=%b, want 0/0/1",
                  state, trap, mif.mem_req);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      pulse_reset();
      for (int c = 0; c < 4; c++) begin
         mif.mem_ready = 1'b0;
         #2;
         n_vec++;
         if (trap !== 1'b0) begin
            n_err++;
            $display("FAIL early_timeout c=%0d: trap=%b want 0", c, trap);
         end
         @(negedge clk);
      end
      #2;
      n_vec++;
      if (trap !== 1'b1 || state !== 3'd5 || mif.mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL fetch_timeout: trap=%b state=%0d req=%b, want 1/5/0",
                  trap, state, mif.mem_req);
      end
      pulse_reset();
      opcode = 7'b0110011;
      for (int c = 0; c < 4; c++) begin
         mif.mem_ready = (c == 3);
         @(negedge clk);
      end
      #2;
      n_vec++;
      if (state !== 3'd1 || trap !== 1'b0) begin
         n_err++;
         $display("FAIL ready_beats_timeout: state=%0d trap=%b, want 1/0", state, trap);
      end
      pulse_reset();
      opcode = 7'b0000011;
      for (int c = 0; c < 7; c++) begin
         mif.mem_ready = (c == 0);
         @(negedge clk);
      end
      #2;
      n_vec++;
      if (trap !== 1'b1 || state !== 3'd5) begin
         n_err++;
         $display("FAIL memory_timeout: trap=%b state=%0d, want 1/5", trap, state);
      end
   endtask

   task automatic test_wrap();
      pulse_reset();
      mif.mem_ready = 1'b0;
      force dut.retire_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.retire_q;
      exp_ret = 32'hFFFF_FFFF;
      run_instr(4, 3'b000, 1'b0, 1'b1, 0, 0);
   endtask

   task automatic test_reset_mid_memory();
      pulse_reset();
      opcode = 7'b0100011;
      for (int c = 0; c < 3; c++) begin
         mif.mem_ready = (c == 0);
         @(negedge clk);
      end
      mif.mem_ready = 1'b0;
      #2;
      n_vec++;
      if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1) begin
         n_err++;
         $display("FAIL store_access: req=%b we=%b, want 1/1", mif.mem_req, mif.mem_we);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if (mif.mem_req !== 1'b0 || mif.mem_we !== 1'b0 || state !== 3'd0) begin
         n_err++;
         $display("FAIL reset_mid_memory: req=%b we=%b state=%0d, want 0/0/0",
                  mif.mem_req, mif.mem_we, state);
      end
      @(negedge clk);
      rst = 1'b1;
      exp_ret = 32'd0;
      #2;
      n_vec++;
      if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0 || retire_count !== 32'd0) begin
         n_err++;
         $display("FAIL refetch_after_reset: req=%b we=%b ret=%h, want 1/0/0",
                  mif.mem_req, mif.mem_we, retire_count);
      end
      @(negedge clk);
   endtask

   initial begin
      mif.mem_ready = 1'b0;
      test_reset();
      test_rtype_add();
      test_load_delay();
      test_branch();
      test_back_to_back();
      test_illegal();
      test_timeout();
      test_wrap();
      test_reset_mid_memory();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
